// File: rtl/bridge_demux4.sv
// 1-to-4 register-level bus distributor: decodes a CPU access onto one of four
// req/ack slaves, returns the registered read data/status, and aborts on timeout.
module bridge_demux4 #(
  parameter logic [17:0] BASE_HI = 18'h0001,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [3:0]  dev_req,
  output logic        dev_we,
  output logic [11:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [3:0]  dev_ack,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1,
  input  logic [31:0] dev_rdata2,
  input  logic [31:0] dev_rdata3
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  sel, sel_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        busy_nx, rvalid_nx, err_nx, we_nx;
  logic [31:0] rdata_nx, wdata_nx, rdata_sel;
  logic [3:0]  req_nx;
  logic [11:0] addr_nx;
  logic        ack_sel;

  always_comb begin
    rdata_sel = dev_rdata0;
    case (sel)
      2'd0: rdata_sel = dev_rdata0;
      2'd1: rdata_sel = dev_rdata1;
      2'd2: rdata_sel = dev_rdata2;
      2'd3: rdata_sel = dev_rdata3;
      default: rdata_sel = dev_rdata0;
    endcase
  end

  // Only the selected slave's ack counts; strays on other ports fall out here.
  assign ack_sel = dev_ack[sel];

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    cnt_nx    = cnt;
    busy_nx   = cpu_busy;
    rvalid_nx = 1'b0;
    rdata_nx  = cpu_rdata;
    err_nx    = cpu_err;
    req_nx    = dev_req;
    we_nx     = dev_we;
    addr_nx   = dev_addr;
    wdata_nx  = dev_wdata;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          busy_nx = 1'b1;
          if (cpu_addr[31:14] == BASE_HI) begin
            state_nx = WAIT;
            sel_nx   = cpu_addr[13:12];
            cnt_nx   = 8'd0;
            req_nx   = 4'b0001 << cpu_addr[13:12];
            we_nx    = cpu_we;
            addr_nx  = cpu_addr[11:0];
            wdata_nx = cpu_wdata;
          end else begin
            state_nx  = RESP;
            rvalid_nx = 1'b1;
            rdata_nx  = 32'd0;
            err_nx    = 1'b1;
          end
        end
      end
      WAIT: begin
        // Ack is tested before the timeout so a last-cycle ack still succeeds.
        if (ack_sel) begin
          state_nx  = RESP;
          rvalid_nx = 1'b1;
          rdata_nx  = rdata_sel;
          err_nx    = 1'b0;
          req_nx    = 4'b0000;
        end else if (cnt == CNT_LAST) begin
          state_nx  = RESP;
          rvalid_nx = 1'b1;
          rdata_nx  = 32'd0;
          err_nx    = 1'b1;
          req_nx    = 4'b0000;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        req_nx   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= 2'd0;
      cnt        <= 8'd0;
      cpu_busy   <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= 32'd0;
      cpu_err    <= 1'b0;
      dev_req    <= 4'b0000;
      dev_we     <= 1'b0;
      dev_addr   <= 12'd0;
      dev_wdata  <= 32'd0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      cnt        <= cnt_nx;
      cpu_busy   <= busy_nx;
      cpu_rvalid <= rvalid_nx;
      cpu_rdata  <= rdata_nx;
      cpu_err    <= err_nx;
      dev_req    <= req_nx;
      dev_we     <= we_nx;
      dev_addr   <= addr_nx;
      dev_wdata  <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_bridge_demux4.sv
// Scoreboard bench for bridge_demux4: directed plan cases plus random accesses
// checked against a transaction-level model of the decode/ack/timeout rules.
module tb_bridge_demux4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic [3:0]  dev_req, dev_ack;
  logic        dev_we;
  logic [11:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] rd_in [4];

  bridge_demux4 #(.BASE_HI(18'h0001), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack),
    .dev_rdata0(rd_in[0]), .dev_rdata1(rd_in[1]), .dev_rdata2(rd_in[2]), .dev_rdata3(rd_in[3])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  onehot;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          req_len;
    int          busy_len;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what a transaction must produce given where the slave acks (d).
  function automatic exp_t model(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                 input int d, input logic [31:0] rd);
    exp_t e;
    e.we = we; e.addr = a[11:0]; e.wdata = wd;
    if (a[31:14] != 18'h0001) begin
      e.rdata = 0; e.err = 1; e.onehot = 0; e.req_len = 0; e.busy_len = 1;
    end else begin
      e.onehot = 4'(1 << a[13:12]);
      if (d < TIMEOUT) begin
        e.rdata = rd; e.err = 0; e.req_len = d + 1; e.busy_len = d + 2;
      end else begin
        e.rdata = 0; e.err = 1; e.req_len = TIMEOUT; e.busy_len = TIMEOUT + 1;
      end
    end
    return e;
  endfunction

  // Monitor: per-cycle dev_* checks and per-response scoreboard pops.
  int rq = 0, bq = 0;
  always @(negedge clk) begin
    if (!reset) begin
      rq = 0; bq = 0;
    end else begin
      if (cpu_busy) bq++;
      if (dev_req != 4'b0) begin
        rq++;
        if (q.size() == 0) check("dev_req_spurious", {28'd0, dev_req}, 32'd0);
        else begin
          check("dev_req", {28'd0, dev_req}, {28'd0, q[0].onehot});
          check("dev_addr", {20'd0, dev_addr}, {20'd0, q[0].addr});
          check("dev_we", {31'd0, dev_we}, {31'd0, q[0].we});
          check("dev_wdata", dev_wdata, q[0].wdata);
        end
      end
      if (cpu_rvalid) begin
        if (q.size() == 0) check("rvalid_spurious", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("cpu_rdata", cpu_rdata, e.rdata);
          check("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
          check("dev_req_len", rq, e.req_len);
          check("busy_len", bq, e.busy_len);
        end
        rq = 0; bq = 0;
      end
    end
  end

  // Drive one access from a negedge with the DUT idle; slave acks in WAIT cycle d.
  task automatic do_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input int d, input logic [31:0] rd, input bit stray_all);
    logic [3:0] smask;
    int k;
    smask = 4'(1 << a[13:12]);
    q.push_back(model(a, we, wd, d, rd));
    cpu_req = 1; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 0;
    k = 0;
    while (cpu_busy && k < 400) begin
      for (int i = 0; i < 4; i++) rd_in[i] = $urandom;
      dev_ack = stray_all ? ~smask : (4'($urandom) & ~smask);
      if (k == d) begin
        dev_ack = dev_ack | smask;
        rd_in[a[13:12]] = rd;
      end
      cpu_req = 1'($urandom);
      cpu_addr = $urandom;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    cpu_req = 0; dev_ack = 0;
    if (k >= 400) check("txn_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int d;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; dev_ack = 0;
    for (int i = 0; i < 4; i++) rd_in[i] = 0;
    reset = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, cpu_busy}, 32'd0);
    check("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err", {31'd0, cpu_err}, 32'd0);
    check("rst_dev_req", {28'd0, dev_req}, 32'd0);
    check("rst_dev_we", {31'd0, dev_we}, 32'd0);
    check("rst_dev_addr", {20'd0, dev_addr}, 32'd0);
    check("rst_dev_wdata", dev_wdata, 32'd0);
    reset = 1;
    @(negedge clk);

    do_txn(32'h0000_6010, 1'b0, 32'h0, 3, 32'hCAFE_0002, 0);
    do_txn(32'h0000_4004, 1'b1, 32'h1234_5678, 0, 32'h5555_AAAA, 0);
    do_txn(32'h0000_8000, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 0);
    do_txn(32'h0000_7008, 1'b0, 32'h0, 1000, 32'h0, 1);
    do_txn(32'h0000_5ABC, 1'b0, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D, 0);
    do_txn(32'h0000_7FFC, 1'b0, 32'h0, TIMEOUT, 32'h1111_2222, 0);

    // Reset in the middle of a WAIT: everything drops at once, no response.
    q.push_back(model(32'h0000_5020, 1'b0, 32'h0, 1000, 32'h0));
    cpu_req = 1; cpu_addr = 32'h0000_5020; cpu_we = 0;
    @(posedge clk); @(negedge clk); cpu_req = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #2 reset = 0;
    q.delete();
    #1;
    check("midrst_dev_req", {28'd0, dev_req}, 32'd0);
    check("midrst_busy", {31'd0, cpu_busy}, 32'd0);
    check("midrst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    do_txn(32'h0000_5020, 1'b0, 32'h0, 2, 32'hABCD_0001, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        a = $urandom;
        if (a[31:14] == 18'h0001) a[31] = 1'b1;
      end else a = {18'h0001, 14'($urandom)};
      d = $urandom_range(0, TIMEOUT + 2);
      do_txn(a, 1'($urandom), $urandom, d, $urandom, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
